// File: rtl/df_agc_pkg.sv
// rtl/df_agc_pkg.sv - shared widths, register map and reset constants for the AGC stage
package df_agc_pkg;

  localparam int SAMPLE_W  = 18;
  localparam int GAIN_W    = 20;
  localparam int ACC_W     = 32;
  localparam int SAT_LIMIT = 131071;

  typedef enum logic [1:0] {
    AGC_CTRL  = 2'd0,
    AGC_REF   = 2'd1,
    AGC_MGAIN = 2'd2,
    AGC_GAIN  = 2'd3
  } agcReg_e;

  localparam logic [16:0]       REF_RST   = 17'h08000;
  localparam logic [GAIN_W-1:0] MGAIN_RST = 20'h10000;
  localparam logic [ACC_W-1:0]  ACC_RST   = 32'h1000_0000;
  localparam logic [3:0]        SHIFT_RST = 4'd4;

  function automatic logic [31:0] mergeBytes(input logic [31:0] cur,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = cur;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[i*8 +: 8] = wdata[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/df_agc_if.sv
// rtl/df_agc_if.sv - sample stream and register bus bundle for the AGC stage
interface df_agc_if;
  import df_agc_pkg::*;

  logic                       clkEn;
  logic signed [SAMPLE_W-1:0] agcIn;
  logic                       cs;
  logic                       wr0, wr1, wr2, wr3;
  logic [12:0]                addr;
  logic [31:0]                din;
  logic [31:0]                dout;
  logic signed [SAMPLE_W-1:0] agcOut;
  logic                       clkEnOut;

  modport master (
    output clkEn, agcIn, cs, wr0, wr1, wr2, wr3, addr, din,
    input  dout, agcOut, clkEnOut
  );

  modport slave (
    input  clkEn, agcIn, cs, wr0, wr1, wr2, wr3, addr, din,
    output dout, agcOut, clkEnOut
  );
endinterface

// File: rtl/df_agc_loop.sv
// rtl/df_agc_loop.sv - integrating gain loop: error, shift, saturating accumulate, MGAIN preload
module df_agc_loop
  import df_agc_pkg::*;
(
  input  logic                       clk,
  input  logic                       resetN,
  input  logic                       update,
  input  logic signed [SAMPLE_W-1:0] agcOut,
  input  logic [16:0]                refLevel,
  input  logic [3:0]                 loopShift,
  input  logic                       preload,
  input  logic [GAIN_W-1:0]          manualGain,
  output logic [ACC_W-1:0]           gainAcc
);

  logic [16:0]        mag;
  logic signed [17:0] err;
  logic [3:0]         shiftAmt;
  logic signed [33:0] delta;
  logic signed [33:0] sum;
  logic [ACC_W-1:0]   clamped;

  // agcOut never reaches -131072, so the magnitude always fits 17 bits
  assign mag      = agcOut[17] ? 17'(-agcOut) : 17'(agcOut);
  assign err      = $signed({1'b0, refLevel}) - $signed({1'b0, mag});
  assign shiftAmt = (loopShift > 4'd11) ? 4'd11 : loopShift;
  assign delta    = $signed({{16{err[17]}}, err}) <<< shiftAmt;
  assign sum      = $signed({2'b00, gainAcc}) + delta;

  always_comb begin
    clamped = sum[31:0];
    if (sum[33])      clamped = '0;
    else if (sum[32]) clamped = '1;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)      gainAcc <= ACC_RST;
    else if (preload) gainAcc <= {manualGain, 12'b0};
    else if (update)  gainAcc <= clamped;
  end

endmodule

// File: rtl/df_agc.sv
// rtl/df_agc.sv - AGC stage: register file, 3-stage scale/saturate pipeline, bus readback
module df_agc
  import df_agc_pkg::*;
(
  input  logic    clk,
  input  logic    resetN,
  df_agc_if.slave bus
);

  localparam logic [31:0]        CTRL_MASK  = 32'h0000_0F03;
  localparam logic [31:0]        REF_MASK   = 32'h0001_FFFF;
  localparam logic [31:0]        MGAIN_MASK = 32'h000F_FFFF;
  localparam logic signed [21:0] SCALED_MAX = 22'(SAT_LIMIT);
  localparam logic signed [21:0] SCALED_MIN = -SCALED_MAX;

  logic [3:0]                 byteEn;
  agcReg_e                    sel;
  logic                       busWr;
  logic                       unusedAddr;
  logic [31:0]                ctrlReg, refReg, mgainReg;
  logic [31:0]                ctrlNext, refNext, mgainNext;
  logic                       enable, freeze;
  logic [3:0]                 loopShift;
  logic [GAIN_W-1:0]          gain;
  logic [ACC_W-1:0]           gainAcc;
  logic                       s1Valid, s2Valid, outValid;
  logic signed [SAMPLE_W-1:0] s1Data, outData, satVal;
  logic signed [37:0]         product, s2Prod;
  logic signed [21:0]         scaled;

  assign byteEn     = {bus.wr3, bus.wr2, bus.wr1, bus.wr0};
  assign sel        = agcReg_e'(bus.addr[3:2]);
  assign busWr      = bus.cs && (byteEn != 4'b0);
  assign unusedAddr = ^{bus.addr[12:4], bus.addr[1:0]};

  assign ctrlNext  = mergeBytes(ctrlReg,  bus.din, byteEn) & CTRL_MASK;
  assign refNext   = mergeBytes(refReg,   bus.din, byteEn) & REF_MASK;
  assign mgainNext = mergeBytes(mgainReg, bus.din, byteEn) & MGAIN_MASK;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      ctrlReg  <= {20'b0, SHIFT_RST, 8'b0};
      refReg   <= {15'b0, REF_RST};
      mgainReg <= {12'b0, MGAIN_RST};
    end else if (busWr) begin
      case (sel)
        AGC_CTRL:  ctrlReg  <= ctrlNext;
        AGC_REF:   refReg   <= refNext;
        AGC_MGAIN: mgainReg <= mgainNext;
        default:   ;
      endcase
    end
  end

  assign enable    = ctrlReg[0];
  assign freeze    = ctrlReg[1];
  assign loopShift = ctrlReg[11:8];
  assign gain      = enable ? gainAcc[31:12] : mgainReg[GAIN_W-1:0];

  df_agc_loop uLoop (
    .clk        (clk),
    .resetN     (resetN),
    .update     (outValid && enable && !freeze),
    .agcOut     (outData),
    .refLevel   (refReg[16:0]),
    .loopShift  (loopShift),
    .preload    (busWr && (sel == AGC_MGAIN)),
    .manualGain (mgainNext[GAIN_W-1:0]),
    .gainAcc    (gainAcc)
  );

  // Gain is unsigned, so it is zero-extended before the signed multiply
  assign product = $signed({{20{s1Data[17]}}, s1Data}) * $signed({18'b0, gain});
  assign scaled  = 22'(s2Prod >>> 16);

  always_comb begin
    satVal = scaled[SAMPLE_W-1:0];
    if (scaled > SCALED_MAX)      satVal = 18'(SCALED_MAX);
    else if (scaled < SCALED_MIN) satVal = 18'(SCALED_MIN);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      s1Valid  <= 1'b0;
      s2Valid  <= 1'b0;
      outValid <= 1'b0;
      s1Data   <= '0;
      s2Prod   <= '0;
      outData  <= '0;
    end else begin
      s1Valid  <= bus.clkEn;
      s2Valid  <= s1Valid;
      outValid <= s2Valid;
      if (bus.clkEn) s1Data  <= bus.agcIn;
      if (s1Valid)   s2Prod  <= product;
      if (s2Valid)   outData <= satVal;
    end
  end

  assign bus.agcOut   = outData;
  assign bus.clkEnOut = outValid;

  always_comb begin
    bus.dout = '0;
    if (bus.cs) begin
      case (sel)
        AGC_CTRL:  bus.dout = ctrlReg;
        AGC_REF:   bus.dout = refReg;
        AGC_MGAIN: bus.dout = mgainReg;
        default:   bus.dout = {12'b0, gain};
      endcase
    end
  end

endmodule
